// File: rtl/life_state_uart_dump_if.sv
// life_state_uart_dump_if: dump request, array read port and UART status grouped for the dump block.
interface life_state_uart_dump_if;
   logic        start;
   logic [1:0]  row_sel;
   logic [15:0] row_data;
   logic        tx;
   logic        busy;
   logic        done;
   modport master (output start, row_data, input row_sel, tx, busy, done);
   modport slave  (input start, row_data, output row_sel, tx, busy, done);
endinterface

// File: rtl/life_state_uart_dump.sv
// life_state_uart_dump: snapshots the 4 life-array rows and sends them as an 8N1 UART frame.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte over the 8 data bytes.
module life_state_uart_dump #(
   parameter int          CLKS_PER_BIT = 868,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   life_state_uart_dump_if.slave bus
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef DUMP_CHECKSUM_EN
   localparam logic [3:0] LAST_BYTE = 4'd9;
`else
   localparam logic [3:0] LAST_BYTE = 4'd8;
`endif
   typedef enum logic [2:0] {IDLE, SNAP, LOAD, START, DATA, STOP, FIN} state_t;
   state_t        state_q, state_d;
   logic [1:0]    row_q, row_d;
   logic [15:0]   shadow_q [4];
   logic [15:0]   shadow_d [4];
   logic [3:0]    byte_q, byte_d;
   logic [2:0]    bit_q, bit_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    byte_sel;
   logic [7:0]    row_byte;
   logic [1:0]    ri;
   logic          baud_end;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]    csum;
`endif
   // Frame index 1..8 maps to row (i-1)/2, odd indices carry the high byte.
   always_comb begin
      ri = 2'((byte_q - 4'd1) >> 1);
      row_byte = byte_q[0] ? shadow_q[ri][15:8] : shadow_q[ri][7:0];
`ifdef DUMP_CHECKSUM_EN
      csum = '0;
      for (int i = 0; i < 4; i++) csum = csum ^ shadow_q[i][15:8] ^ shadow_q[i][7:0];
      byte_sel = (byte_q == 4'd0) ? HEADER : (byte_q == 4'd9) ? csum : row_byte;
`else
      byte_sel = (byte_q == 4'd0) ? HEADER : row_byte;
`endif
   end
   assign baud_end = (baud_q == BAUD_LAST);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         row_q    <= '0;
         shadow_q <= '{default: '0};
         byte_q   <= '0;
         bit_q    <= '0;
         baud_q   <= '0;
         shreg_q  <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         shadow_q <= shadow_d;
         byte_q   <= byte_d;
         bit_q    <= bit_d;
         baud_q   <= baud_d;
         shreg_q  <= shreg_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      shadow_d = shadow_q;
      byte_d   = byte_q;
      bit_d    = bit_q;
      baud_d   = baud_q;
      shreg_d  = shreg_q;
      case (state_q)
         IDLE: begin
            row_d  = '0;
            byte_d = '0;
            state_d = bus.start ? SNAP : IDLE;
         end
         SNAP: begin
            shadow_d[row_q] = bus.row_data;
            row_d = row_q + 2'd1;
            state_d = (row_q == 2'd3) ? LOAD : SNAP;
         end
         LOAD: begin
            shreg_d = byte_sel;
            baud_d  = '0;
            state_d = START;
         end
         START: begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
            bit_d  = '0;
            state_d = baud_end ? DATA : START;
         end
         DATA: begin
            baud_d  = baud_end ? '0 : baud_q + 1'b1;
            shreg_d = baud_end ? shreg_q >> 1 : shreg_q;
            bit_d   = baud_end ? bit_q + 3'd1 : bit_q;
            state_d = (baud_end && bit_q == 3'd7) ? STOP : DATA;
         end
         STOP: begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
            byte_d = baud_end ? byte_q + 4'd1 : byte_q;
            state_d = !baud_end ? STOP : (byte_q == LAST_BYTE) ? FIN : LOAD;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign bus.row_sel = (state_q == SNAP) ? row_q : 2'd0;
   assign bus.tx      = (state_q == START) ? 1'b0 : (state_q == DATA) ? shreg_q[0] : 1'b1;
   assign bus.busy    = (state_q != IDLE) && (state_q != FIN);
   assign bus.done    = (state_q == FIN);
endmodule

// File: tb/tb_life_state_uart_dump.sv
// tb_life_state_uart_dump: directed checks of snapshot, frame contents, timing and async reset.
module tb_life_state_uart_dump;
   localparam int CPB = 4;
`ifdef DUMP_CHECKSUM_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [15:0] rows [4];
   logic [7:0] exp_b [10] = '{8'hA5, 8'h80, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'hA7};
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   life_state_uart_dump_if bus();
   assign bus.row_data = rows[bus.row_sel];
   life_state_uart_dump #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_rows();
      rows[0] = 16'h8001; rows[1] = 16'h0000; rows[2] = 16'hFFFF; rows[3] = 16'h1234;
   endtask

   task automatic pulse_start();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
   endtask

   task automatic wait_low();
      int n = 0;
      while (bus.tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rx_start_found", 32'(n < 2000), 1);
   endtask

   // Samples each bit mid-period; returns during the stop bit.
   task automatic rx_byte(output logic [7:0] b);
      wait_low();
      repeat (2) @(negedge clk);
      chk("rx_start_mid", bus.tx, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         b[i] = bus.tx;
      end
      repeat (4) @(negedge clk);
      chk("rx_stop", bus.tx, 1);
   endtask

   task automatic rx_bytes(input int first, input int last);
      logic [7:0] b;
      for (int i = first; i <= last; i++) begin
         rx_byte(b);
         chk($sformatf("byte%0d", i), b, exp_b[i]);
      end
   endtask

   task automatic wait_done();
      int d = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) d++;
      end
      chk("done_pulses", d, 1);
      chk("busy_after", bus.busy, 0);
   endtask

   initial begin
      int n;
      int low_cnt;
      logic low_end;
      logic quiet;
      bus.start = 1'b0;
      set_rows();
      // Test 1: idle after reset
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle", {bus.tx, bus.busy, bus.done, bus.row_sel}, 5'b10000);
      end
      // Test 2: full frame
      pulse_start();
      chk("busy_start", bus.busy, 1);
      rx_bytes(0, NB - 1);
      wait_done();
      // Test 3: start bit width and accept-to-done latency
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      n = 0;
      low_cnt = 0;
      low_end = 1'b0;
      while (n < 1000) begin
         n++;
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.tx === 1'b0 && !low_end) low_cnt++;
         if (bus.tx === 1'b1 && low_cnt > 0) low_end = 1'b1;
         if (bus.done === 1'b1) break;
      end
      chk("start_bit_len", low_cnt, CPB);
      chk("latency", n, 1 + 4 + NB * (1 + 10 * CPB));
      // Test 4: array change after snapshot, ignored start mid-frame
      repeat (5) @(negedge clk);
      pulse_start();
      rx_bytes(0, 0);
      rows[0] = 16'h0; rows[1] = 16'h0; rows[2] = 16'h0; rows[3] = 16'h0;
      pulse_start();
      rx_bytes(1, NB - 1);
      wait_done();
      quiet = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0) quiet = 1'b0;
      end
      chk("no_second_frame", quiet, 1);
      // Test 5: async reset during DATA bits of byte 3
      set_rows();
      pulse_start();
      rx_bytes(0, 2);
      wait_low();
      repeat (8) @(negedge clk);
      chk("in_frame_busy", bus.busy, 1);
      reset = 1'b0;
      #1;
      chk("rst_tx", bus.tx, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_idle", {bus.tx, bus.busy, bus.row_sel}, 4'b1000);
      pulse_start();
      rx_bytes(0, NB - 1);
      wait_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
